dm9000a_iow_arbiter: RTL

DM9000A_IOW_ARBITER -- requirements
Module: dm9000a_iow_arbiter

---
 rtl/dm9000a_iow_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dm9000a_iow_arbiter.sv
// Round-robin arbiter that shares one DM9000A IOW (register write) engine
// between three requesters.
//
// Ports:
//   iDm9000aClk                  clock, all state changes on rising edge
//   iRst                         synchronous active-high reset
//   iReqN_RunStart               level request, held until oReqN_RunEnd
//   iReqN_Reg / iReqN_Data       register address / write data per requester
//   oReqN_RunEnd                 single-cycle completion pulse per requester
//   out_to_Dm9000a_Iow_RunStart  start level to the IOW engine (high in GRANT)
//   out_to_Dm9000a_Iow_Reg/Data  latched address/data to engine, 0 outside GRANT
//   in_from_Dm9000a_Iow_RunEnd   engine done level
//   oGrant                       granted requester index, 2'd3 when none
//   oBusy                        high whenever not IDLE
//   oTimeoutErr / oTimeoutId     sticky timeout flag / last requester that timed out
module dm9000a_iow_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd5000
) (
    input  logic        iDm9000aClk,
    input  logic        iRst,
    input  logic        iReq0_RunStart,
    input  logic        iReq1_RunStart,
    input  logic        iReq2_RunStart,
    input  logic [15:0] iReq0_Reg,
    input  logic [15:0] iReq1_Reg,
    input  logic [15:0] iReq2_Reg,
    input  logic [15:0] iReq0_Data,
    input  logic [15:0] iReq1_Data,
    input  logic [15:0] iReq2_Data,
    output logic        oReq0_RunEnd,
    output logic        oReq1_RunEnd,
    output logic        oReq2_RunEnd,
    output logic        out_to_Dm9000a_Iow_RunStart,
    output logic [15:0] out_to_Dm9000a_Iow_Reg,
    output logic [15:0] out_to_Dm9000a_Iow_Data,
    input  logic        in_from_Dm9000a_Iow_RunEnd,
    output logic [1:0]  oGrant,
    output logic        oBusy,
    output logic        oTimeoutErr,
    output logic [1:0]  oTimeoutId
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [15:0] reg_q, reg_d;
    logic [15:0] data_q, data_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic [1:0]  timeout_id_q, timeout_id_d;

    logic [2:0]  req;
    logic [1:0]  rr_start;
    logic [1:0]  pick;
    logic [15:0] pick_reg;
    logic [15:0] pick_data;
    logic        in_grant;
    logic        eng_done;
    logic        timeout_hit;
    logic        finish;

    assign req      = {iReq2_RunStart, iReq1_RunStart, iReq0_RunStart};
    assign rr_start = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;

    // Round-robin pick: first active request at or after rr_start, wrapping.
    // The result is only used when at least one request is high.
    always_comb begin
        pick = 2'd0;
        case (rr_start)
            2'd0: begin
                if (req[0])      pick = 2'd0;
                else if (req[1]) pick = 2'd1;
                else             pick = 2'd2;
            end
            2'd1: begin
                if (req[1])      pick = 2'd1;
                else if (req[2]) pick = 2'd2;
                else             pick = 2'd0;
            end
            default: begin
                if (req[2])      pick = 2'd2;
                else if (req[0]) pick = 2'd0;
                else             pick = 2'd1;
            end
        endcase
    end

    always_comb begin
        pick_reg  = iReq2_Reg;
        pick_data = iReq2_Data;
        case (pick)
            2'd0: begin
                pick_reg  = iReq0_Reg;
                pick_data = iReq0_Data;
            end
            2'd1: begin
                pick_reg  = iReq1_Reg;
                pick_data = iReq1_Data;
            end
            default: begin
                pick_reg  = iReq2_Reg;
                pick_data = iReq2_Data;
            end
        endcase
    end

    assign in_grant = (state_q == StGrant);
    assign eng_done = in_grant & in_from_Dm9000a_Iow_RunEnd;
    // Engine completion wins over a timeout landing on the same cycle.
    assign timeout_hit = in_grant & ~in_from_Dm9000a_Iow_RunEnd &
                         (wait_cnt_q == (TIMEOUT_CYCLES - 16'd1));
    assign finish = eng_done | timeout_hit;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        reg_d         = reg_q;
        data_d        = data_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        timeout_id_d  = timeout_id_q;

        case (state_q)
            StIdle: begin
                if (req != 3'b000) begin
                    state_d    = StGrant;
                    grant_d    = pick;
                    reg_d      = pick_reg;
                    data_d     = pick_data;
                    wait_cnt_d = 16'd0;
                end
            end
            StGrant: begin
                wait_cnt_d = wait_cnt_q + 16'd1;
                if (finish) begin
                    state_d      = StRelease;
                    last_grant_d = grant_q;
                    grant_d      = 2'd3;
                end
                if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                    timeout_id_d  = grant_q;
                end
            end
            StRelease: begin
                // Wait for the engine to drop its done level before re-arming.
                if (!in_from_Dm9000a_Iow_RunEnd) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iDm9000aClk) begin
        if (iRst) begin
            state_q       <= StIdle;
            grant_q       <= 2'd3;
            last_grant_q  <= 2'd2;
            reg_q         <= 16'h0000;
            data_q        <= 16'h0000;
            wait_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= 2'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            reg_q         <= reg_d;
            data_q        <= data_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            timeout_id_q  <= timeout_id_d;
        end
    end

    assign out_to_Dm9000a_Iow_RunStart = in_grant;
    assign out_to_Dm9000a_Iow_Reg      = in_grant ? reg_q : 16'h0000;
    assign out_to_Dm9000a_Iow_Data     = in_grant ? data_q : 16'h0000;

    // A reset landing on the completion cycle aborts the transaction silently.
    assign oReq0_RunEnd = finish & ~iRst & (grant_q == 2'd0);
    assign oReq1_RunEnd = finish & ~iRst & (grant_q == 2'd1);
    assign oReq2_RunEnd = finish & ~iRst & (grant_q == 2'd2);

    assign oGrant      = grant_q;
    assign oBusy       = (state_q != StIdle);
    assign oTimeoutErr = timeout_err_q;
    assign oTimeoutId  = timeout_id_q;

endmodule
